// File: rtl/veh_emu_pkg.sv
// Shared types and helpers for the vehicle sensor emulator.
//   cmd_op_t    : passage command encoding (ENTER, EXIT, BALK_S1, BALK_S2)
//   emu_state_t : emulator FSM states
//   lead_mask   : {S1,S2} pattern with only the leading sensor high
//   is_balk     : true for the two aborted-approach commands
package veh_emu_pkg;

  typedef enum logic [1:0] {
    ENTER   = 2'b00,
    EXIT    = 2'b01,
    BALK_S1 = 2'b10,
    BALK_S2 = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    BOTH  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } emu_state_t;

  // Bit 1 = S1 (outer), bit 0 = S2 (inner).
  function automatic logic [1:0] lead_mask(input cmd_op_t op);
    case (op)
      ENTER, BALK_S1: lead_mask = 2'b10;
      default:        lead_mask = 2'b01;
    endcase
  endfunction

  function automatic logic is_balk(input cmd_op_t op);
    is_balk = op[1];
  endfunction

endpackage

// File: rtl/veh_phase_timer.sv
// Loadable down-counter used for both the sensor phases and the gap.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_load       : load i_load_val this edge (takes priority over counting)
//   i_load_val   : cycles-minus-one for the phase being entered
//   o_expire     : high in the last cycle of the loaded phase (count == 0)
module veh_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/vehicle_sensor_emulator.sv
// Synthetic vehicle passage generator for the two-beam parking sensor pair.
// One command per passage is taken over cmd_valid/cmd_ready and the S1/S2
// level sequence is played out: lead sensor, both, trail sensor, then a
// quiet gap (balks skip straight from lead to gap).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   cmd_valid, cmd_op : command handshake (accepted when cmd_ready is high)
//   cmd_ready         : high only in IDLE
//   S1_out, S2_out    : registered emulated sensor levels
//   busy              : high outside IDLE
//   done              : one-cycle pulse in the final gap cycle
//   enter_count, exit_count, balk_count : saturating passage counters,
//                       present only when VEH_EMU_STATS_EN is defined
module vehicle_sensor_emulator
  import veh_emu_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic             S1_out,
  output logic             S2_out,
  output logic             busy,
  output logic             done
`ifdef VEH_EMU_STATS_EN
  ,
  output logic [CNT_W-1:0] enter_count,
  output logic [CNT_W-1:0] exit_count,
  output logic [CNT_W-1:0] balk_count
`endif
);

  localparam int MAX_CYC = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] PH_LOAD  = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  if (PHASE_CYCLES < 1 || GAP_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("vehicle_sensor_emulator: PHASE_CYCLES, GAP_CYCLES and CNT_W must be >= 1");
  end

  emu_state_t    r_state;
  emu_state_t    w_next;
  cmd_op_t       r_op;
  cmd_op_t       w_op;
  logic          w_accept;
  logic          w_expire;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic [1:0]    w_lvl_next;
  logic [1:0]    r_lvl;

  assign w_accept = (r_state == IDLE) && cmd_valid;
  // On the accepting edge the op register is not yet loaded, so the
  // first lead level comes straight from the command input.
  assign w_op     = w_accept ? cmd_op_t'(cmd_op) : r_op;

  // Every transition enters a new timed state, so the timer reloads on
  // any state change; only GAP uses the gap length.
  assign w_load     = (w_next != r_state);
  assign w_load_val = (w_next == GAP) ? GAP_LOAD : PH_LOAD;

  veh_phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire   (w_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      r_op <= cmd_op_t'(cmd_op);
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_next = LEAD;
      LEAD:    if (w_expire)  w_next = is_balk(r_op) ? GAP : BOTH;
      BOTH:    if (w_expire)  w_next = TRAIL;
      TRAIL:   if (w_expire)  w_next = GAP;
      GAP:     if (w_expire)  w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // Output logic: sensor levels are decoded from the next state and
  // registered, so they line up with the state and cannot glitch. Each
  // phase boundary flips exactly one sensor.
  always_comb begin
    w_lvl_next = 2'b00;
    case (w_next)
      LEAD:    w_lvl_next = lead_mask(w_op);
      BOTH:    w_lvl_next = 2'b11;
      TRAIL:   w_lvl_next = ~lead_mask(w_op);
      default: w_lvl_next = 2'b00;
    endcase
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == GAP) && w_expire;

  always_ff @(posedge clk) begin
    if (reset)
      r_lvl <= 2'b00;
    else
      r_lvl <= w_lvl_next;
  end

  assign S1_out = r_lvl[1];
  assign S2_out = r_lvl[0];

`ifdef VEH_EMU_STATS_EN
  logic [CNT_W-1:0] r_enter_cnt;
  logic [CNT_W-1:0] r_exit_cnt;
  logic [CNT_W-1:0] r_balk_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enter_cnt <= '0;
      r_exit_cnt  <= '0;
      r_balk_cnt  <= '0;
    end else if (done) begin
      case (r_op)
        ENTER:   r_enter_cnt <= sat_inc(r_enter_cnt);
        EXIT:    r_exit_cnt  <= sat_inc(r_exit_cnt);
        default: r_balk_cnt  <= sat_inc(r_balk_cnt);
      endcase
    end
  end

  assign enter_count = r_enter_cnt;
  assign exit_count  = r_exit_cnt;
  assign balk_count  = r_balk_cnt;
`endif

endmodule

// File: tb/tb_vehicle_sensor_emulator.sv
// Testbench for vehicle_sensor_emulator. Instance A uses PHASE=4, GAP=2,
// CNT_W=2; instance B uses PHASE=1, GAP=1. Counter checks are compiled
// in when VEH_EMU_STATS_EN is defined.
module tb_vehicle_sensor_emulator;

  logic clk = 1'b0;
  logic reset;
  logic a_valid, b_valid;
  logic [1:0] a_op, b_op;
  logic a_ready, a_s1, a_s2, a_busy, a_done;
  logic b_ready, b_s1, b_s2, b_busy, b_done;
`ifdef VEH_EMU_STATS_EN
  logic [1:0] a_enter, a_exit, a_balk;
  logic [7:0] b_enter, b_exit, b_balk;
`endif

  int errors = 0;
  int checks = 0;
  int m_enter = 0, m_exit = 0, m_balk = 0;

  always #5 clk = ~clk;

  vehicle_sensor_emulator #(.PHASE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(2)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(a_valid), .cmd_op(a_op),
    .cmd_ready(a_ready), .S1_out(a_s1), .S2_out(a_s2), .busy(a_busy), .done(a_done)
`ifdef VEH_EMU_STATS_EN
    , .enter_count(a_enter), .exit_count(a_exit), .balk_count(a_balk)
`endif
  );

  vehicle_sensor_emulator #(.PHASE_CYCLES(1), .GAP_CYCLES(1), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_op(b_op),
    .cmd_ready(b_ready), .S1_out(b_s1), .S2_out(b_s2), .busy(b_busy), .done(b_done)
`ifdef VEH_EMU_STATS_EN
    , .enter_count(b_enter), .exit_count(b_exit), .balk_count(b_balk)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] lvl(input int sel);
    return (sel != 0) ? {b_s1, b_s2} : {a_s1, a_s2};
  endfunction
  function automatic logic rdy(input int sel);
    return (sel != 0) ? b_ready : a_ready;
  endfunction
  function automatic logic bsy(input int sel);
    return (sel != 0) ? b_busy : a_busy;
  endfunction
  function automatic logic dn(input int sel);
    return (sel != 0) ? b_done : a_done;
  endfunction

  // Reference waveform: cycle k (1-based after the accepting edge) of a
  // passage. Phases are lead / both / trail of P cycles each (balks only
  // have the lead phase), followed by the quiet gap.
  function automatic logic [1:0] exp_lvl(input logic [1:0] op, input int k, input int p);
    logic [1:0] lead;
    int nph, ph;
    lead = (op == 2'b00 || op == 2'b10) ? 2'b10 : 2'b01;  // {S1,S2}
    nph  = op[1] ? 1 : 3;
    if (k > nph * p) return 2'b00;
    ph = (k - 1) / p;
    if (ph == 0) return lead;
    if (ph == 1) return 2'b11;
    return ~lead;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [1:0] op);
    if (sel != 0) begin b_valid = v; b_op = op; end
    else          begin a_valid = v; a_op = op; end
  endtask

  // Offer op in the current (IDLE) cycle and check the whole passage.
  // With hold set, cmd_valid stays high carrying next_op so the following
  // command is accepted in the first IDLE cycle after this passage.
  task automatic run_cmd(input int sel, input logic [1:0] op, input bit hold,
                         input logic [1:0] next_op);
    int p, g, len;
    p = (sel != 0) ? 1 : 4;
    g = (sel != 0) ? 1 : 2;
    len = (op[1] ? 1 : 3) * p + g;
    drive(sel, 1'b1, op);
    chk("ready_at_offer", rdy(sel), 1'b1);
    step();
    if (hold) drive(sel, 1'b1, next_op);
    else      drive(sel, 1'b0, 2'b00);
    for (int k = 1; k <= len; k++) begin
      chk($sformatf("lvl op%0d c%0d", op, k), lvl(sel), exp_lvl(op, k, p));
      chk($sformatf("done op%0d c%0d", op, k), dn(sel), (k == len));
      chk($sformatf("ready op%0d c%0d", op, k), rdy(sel), 1'b0);
      chk($sformatf("busy op%0d c%0d", op, k), bsy(sel), 1'b1);
      step();
    end
    chk("ready_after", rdy(sel), 1'b1);
    chk("busy_after", bsy(sel), 1'b0);
    chk("lvl_after", lvl(sel), 2'b00);
    chk("done_after", dn(sel), 1'b0);
    if (sel == 0) begin
      if (op == 2'b00)      m_enter = (m_enter < 3) ? m_enter + 1 : 3;
      else if (op == 2'b01) m_exit  = (m_exit  < 3) ? m_exit  + 1 : 3;
      else                  m_balk  = (m_balk  < 3) ? m_balk  + 1 : 3;
`ifdef VEH_EMU_STATS_EN
      chk("enter_count", a_enter, m_enter);
      chk("exit_count",  a_exit,  m_exit);
      chk("balk_count",  a_balk,  m_balk);
`endif
    end
  endtask

  task automatic idle_cycles(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_lvl", lvl(sel), 2'b00);
      chk("idle_ready", rdy(sel), 1'b1);
      chk("idle_done", dn(sel), 1'b0);
      step();
    end
  endtask

  initial begin
    logic [1:0] op, nop;
    bit h;
    reset = 1'b1;
    drive(0, 1'b0, 2'b00);
    drive(1, 1'b0, 2'b00);
    step();
    step();
    // reset state, both instances
    chk("rst_ready_a", a_ready, 1'b1);
    chk("rst_busy_a", a_busy, 1'b0);
    chk("rst_lvl_a", {a_s1, a_s2}, 2'b00);
    chk("rst_done_a", a_done, 1'b0);
    chk("rst_ready_b", b_ready, 1'b1);
    chk("rst_lvl_b", {b_s1, b_s2}, 2'b00);
`ifdef VEH_EMU_STATS_EN
    chk("rst_enter", a_enter, 0);
    chk("rst_exit", a_exit, 0);
    chk("rst_balk", a_balk, 0);
`endif
    reset = 1'b0;
    step();

    // directed single passages
    run_cmd(0, 2'b00, 1'b0, 2'b00);   // ENTER
    idle_cycles(0, 2);
    run_cmd(0, 2'b01, 1'b0, 2'b00);   // EXIT
    idle_cycles(0, 1);
    run_cmd(0, 2'b10, 1'b0, 2'b00);   // BALK_S1
    idle_cycles(0, 1);

    // back-to-back ENTER then EXIT with cmd_valid held
    run_cmd(0, 2'b00, 1'b1, 2'b01);
    run_cmd(0, 2'b01, 1'b0, 2'b00);
    idle_cycles(0, 1);

    // reset in the BOTH phase of an ENTER
    drive(0, 1'b1, 2'b00);
    step();
    drive(0, 1'b0, 2'b00);
    for (int k = 1; k < 6; k++) step();
    chk("mid_lvl_c6", {a_s1, a_s2}, 2'b11);
    reset = 1'b1;
    step();
    chk("rst_mid_lvl_c7", {a_s1, a_s2}, 2'b00);
    chk("rst_mid_done_c7", a_done, 1'b0);
    chk("rst_mid_ready_c7", a_ready, 1'b1);
    reset = 1'b0;
    m_enter = 0; m_exit = 0; m_balk = 0;
    step();
    chk("post_rst_ready", a_ready, 1'b1);
    chk("post_rst_lvl", {a_s1, a_s2}, 2'b00);
    chk("post_rst_done", a_done, 1'b0);
`ifdef VEH_EMU_STATS_EN
    chk("post_rst_enter", a_enter, 0);
`endif
    run_cmd(0, 2'b00, 1'b0, 2'b00);

    // statistics: 3 ENTER, 2 EXIT, 1 BALK_S2 since reset
    run_cmd(0, 2'b00, 1'b0, 2'b00);
    run_cmd(0, 2'b00, 1'b0, 2'b00);
    run_cmd(0, 2'b01, 1'b0, 2'b00);
    run_cmd(0, 2'b01, 1'b0, 2'b00);
    run_cmd(0, 2'b11, 1'b0, 2'b00);
`ifdef VEH_EMU_STATS_EN
    chk("stats_enter_3", a_enter, 3);
    chk("stats_exit_2", a_exit, 2);
    chk("stats_balk_1", a_balk, 1);
`endif
    run_cmd(0, 2'b00, 1'b0, 2'b00);
    run_cmd(0, 2'b00, 1'b0, 2'b00);
`ifdef VEH_EMU_STATS_EN
    chk("stats_enter_sat", a_enter, 3);
`endif

    // randomized command stream on instance A
    op = 2'($urandom_range(0, 3));
    for (int i = 0; i < 20; i++) begin
      nop = 2'($urandom_range(0, 3));
      h   = 1'($urandom_range(0, 1));
      run_cmd(0, op, h, nop);
      if (!h) idle_cycles(0, $urandom_range(0, 3));
      op = nop;
    end
    drive(0, 1'b0, 2'b00);

    // single-cycle phases on instance B
    run_cmd(1, 2'b00, 1'b0, 2'b00);
    op = 2'($urandom_range(0, 3));
    for (int i = 0; i < 8; i++) begin
      nop = 2'($urandom_range(0, 3));
      h   = 1'($urandom_range(0, 1));
      run_cmd(1, op, h, nop);
      if (!h) idle_cycles(1, $urandom_range(0, 2));
      op = nop;
    end
    drive(1, 1'b0, 2'b00);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vehicle_sensor_emulator.md
Name: vehicle_sensor_emulator

Overview:
- Drives the two-beam parking sensor pair (S1 outer, S2 inner) with synthetic vehicle passages.
- Takes one command per passage over a valid/ready handshake and plays out the S1/S2 level sequence for an entry, an exit, or an aborted approach (balk).
- Used as the stimulus end of the detection path: on-board demo mode and closed-loop benches that feed the detector FSM.

Parameters:
- PHASE_CYCLES, 4: clock cycles spent in each sensor phase. Must be >=1.
- GAP_CYCLES, 2: cycles with both sensors low after each passage. Must be >=1.
- CNT_W, 8: width of the statistics counters. Only used with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_op  in  2  00 ENTER, 01 EXIT, 10 BALK_S1, 11 BALK_S2
- cmd_ready  out  1  high only in IDLE
- S1_out  out  1  emulated outer sensor level, registered
- S2_out  out  1  emulated inner sensor level, registered
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of a passage
- enter_count, exit_count, balk_count  out  CNT_W each  present only with VEH_EMU_STATS_EN

Behaviour:
- Reset values: state IDLE, S1_out=0, S2_out=0, done=0, busy=0, cmd_ready=1 from the first cycle after reset, counters=0.
- Handshake:
  - A command is accepted at a clock edge where cmd_valid and cmd_ready are both high; cmd_op is captured at that edge.
  - cmd_valid while busy is ignored and not queued; the source holds it.
- States: IDLE, LEAD, BOTH, TRAIL, GAP. A phase timer counts 0..N-1 in each timed state.
- Lead and trail sensors:
  - ENTER: lead=S1, trail=S2.
  - EXIT: lead=S2, trail=S1.
  - BALK_S1: lead=S1.
  - BALK_S2: lead=S2.
- Transitions:
  - IDLE to LEAD on accept.
  - LEAD to BOTH after PHASE_CYCLES (ENTER/EXIT); LEAD to GAP after PHASE_CYCLES (BALK).
  - BOTH to TRAIL after PHASE_CYCLES.
  - TRAIL to GAP after PHASE_CYCLES.
  - GAP to IDLE after GAP_CYCLES.
- Output levels, registered from next-state so they align with state:
  - LEAD: only the lead sensor high.
  - BOTH: both high.
  - TRAIL: only the trail sensor high.
  - GAP and IDLE: both low.
- Sensor outputs must never glitch, and the two sensors never change on the same edge. The sequence is strictly one sensor change per phase boundary.
- Timing:
  - The first sensor rises in the first cycle after the accepting edge.
  - done=1 in the final GAP cycle only; cmd_ready=1 in the next cycle.
  - ENTER/EXIT occupancy: 3*PHASE_CYCLES+GAP_CYCLES cycles.
  - BALK occupancy: PHASE_CYCLES+GAP_CYCLES cycles.
- Back-to-back commands: at least GAP_CYCLES low cycles separate passages, plus the IDLE accept cycle.
- Reset mid-operation: both sensors low in the cycle after the reset edge. The command is dropped, no done pulse, counters cleared.
- Boundary: PHASE_CYCLES=1 and GAP_CYCLES=1 must work, giving single-cycle phases. The timer width is $clog2(max(PHASE_CYCLES,GAP_CYCLES)+1).

Optional Feature:
- Macro: VEH_EMU_STATS_EN.
- Defined:
  - enter_count, exit_count and balk_count ports exist.
  - The counter for the completed op increments on the done cycle; both BALK ops go to balk_count.
  - Counters saturate at 2^CNT_W-1 and clear on reset.
- Undefined: the ports and counter logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package veh_emu_pkg holds:
  - typedef cmd_op_t (enum logic[1:0] ENTER, EXIT, BALK_S1, BALK_S2)
  - typedef emu_state_t (enum IDLE, LEAD, BOTH, TRAIL, GAP)
- Sub-module veh_phase_timer: loadable down-counter with load value and an expire flag. It is reused for phase and gap timing.

Test Plan:
- ENTER, P=4, G=2, accept at edge 0:
  - S1 only in cycles 1-4, S1&S2 in cycles 5-8, S2 only in cycles 9-12, both low in cycles 13-14.
  - done in cycle 14, cmd_ready in cycle 15.
  - Looped into the detector: exactly one entering pulse, zero exiting pulses.
- EXIT, same parameters: mirror waveform, S2 first. Detector gives one exiting pulse, zero entering pulses.
- BALK_S1, P=4, G=2: S1 high cycles 1-4, low cycles 5-6, done in cycle 6. Detector produces no pulse; S2 stays 0 throughout.
- Commands ENTER then EXIT with cmd_valid held:
  - cmd_ready is low during passage 1.
  - The second accept happens in cycle 15.
  - Both sensors are low for >=2 cycles between passages.
  - Exactly one done per command.
- Reset asserted in cycle 6 (BOTH phase) of an ENTER:
  - S1=S2=0 from cycle 7, no done pulse.
  - cmd_ready high in the first cycle after reset deasserts.
  - A new ENTER then plays its full waveform.
- VEH_EMU_STATS_EN with CNT_W=2:
  - 3 ENTER, 2 EXIT, 1 BALK_S2 give counts 3/2/1.
  - 2 further ENTERs leave enter_count at 3 (saturated).
- P=1, G=1 ENTER: one cycle each of S1, S1&S2, S2, then low; done 4 cycles after accept.
